// File: rtl/flash_loader_pkg.sv
// Shared definitions for the flash-to-memory copy engine: state encoding,
// flash address width and the default busy-handshake timeout.
package flash_loader_pkg;

    localparam int FLASH_AW        = 24;
    localparam int TMO_CYC_DEFAULT = 63;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        REQ,
        XFER,
        WRITE,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/flash_loader.sv
// Boot-time bulk copier: reads bytes one at a time from the DSPI flash reader
// and writes them to a memory write port. Optional checksum: FLASH_LOADER_CHKSUM_EN.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int DST_W   = 22,
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [23:0]         src_addr,
    input  logic [DST_W-1:0]    dst_addr,
    input  logic [LEN_W-1:0]    length,
    input  logic                flash_ready,
    input  logic                flash_busy,
    input  logic [7:0]          flash_dout,
    output logic                flash_cs,
    output logic [23:0]         flash_addr,
    output logic [DST_W-1:0]    mem_addr,
    output logic [7:0]          mem_data,
    output logic                mem_we,
    input  logic                mem_wait,
    output logic                active,
    output logic                done,
    output logic                error,
`ifdef FLASH_LOADER_CHKSUM_EN
    output logic [15:0]         checksum,
`endif
    output logic [LEN_W-1:0]    remaining
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);

    // Handshakes: flash_cs is a request level held until flash_busy is seen
    // (the flash only acts on its rising edge); flash_dout is valid in the
    // cycle flash_busy falls. mem_we is a one-cycle strobe, never raised
    // in a cycle that follows mem_wait=1.
    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            flash_cs   <= 1'b0;
            flash_addr <= '0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we     <= 1'b0;
            active     <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            remaining  <= '0;
`ifdef FLASH_LOADER_CHKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;
`ifdef FLASH_LOADER_CHKSUM_EN
            if (mem_we)
                checksum <= checksum + {8'h00, mem_data};
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        flash_addr <= src_addr;
                        mem_addr   <= dst_addr;
                        remaining  <= length;
                        error      <= 1'b0;
                        active     <= 1'b1;
`ifdef FLASH_LOADER_CHKSUM_EN
                        checksum   <= '0;
`endif
                        state      <= (length == '0) ? DONE : WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (flash_ready && !flash_busy) begin
                        tmo_cnt <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // cs rises one cycle into REQ, so it is high for TMO_CYC cycles before giving up
                    if (flash_busy) begin
                        flash_cs <= 1'b0;
                        state    <= XFER;
                    end else if (tmo_cnt == TMO_W'(TMO_CYC)) begin
                        flash_cs <= 1'b0;
                        error    <= 1'b1;
                        state    <= DONE;
                    end else begin
                        flash_cs <= 1'b1;
                        tmo_cnt  <= tmo_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (!flash_busy) begin
                        mem_data <= flash_dout;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (!mem_wait) begin
                        mem_we <= 1'b1;
                        state  <= NEXT;
                    end
                end
                NEXT: begin
                    flash_addr <= flash_addr + 24'd1;
                    mem_addr   <= mem_addr + DST_W'(1);
                    remaining  <= remaining - LEN_W'(1);
                    tmo_cnt    <= '0;
                    state      <= (remaining == LEN_W'(1)) ? DONE : REQ;
                end
                DONE: begin
                    done   <= 1'b1;
                    active <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
